// File: rtl/core_iencode_pkg.sv
// Shared RV32I encoding definitions: instruction classes, major opcodes and field helpers.
// Used by core_iencode and core_idecode; range helpers matter only when IENC_RANGE_CHECK_EN is defined.
package core_iencode_pkg;

    typedef enum logic [3:0] {
        OPC_R     = 4'd0,
        OPC_I_ALU = 4'd1,
        OPC_LOAD  = 4'd2,
        OPC_S     = 4'd3,
        OPC_B     = 4'd4,
        OPC_JAL   = 4'd5,
        OPC_JALR  = 4'd6,
        OPC_LUI   = 4'd7,
        OPC_AUIPC = 4'd8
    } opclass_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef struct packed {
        logic [31:0] word;
        logic        err;
    } enc_entry_t;

    // Major opcode for a defined class; undefined classes map to OP_I_ALU so the nop shares it.
    function automatic logic [6:0] opcode_of(input opclass_e cls);
        logic [6:0] op;
        op = OP_I_ALU;
        case (cls)
            OPC_R:     op = OP_R;
            OPC_I_ALU: op = OP_I_ALU;
            OPC_LOAD:  op = OP_LOAD;
            OPC_S:     op = OP_S;
            OPC_B:     op = OP_B;
            OPC_JAL:   op = OP_JAL;
            OPC_JALR:  op = OP_JALR;
            OPC_LUI:   op = OP_LUI;
            OPC_AUIPC: op = OP_AUIPC;
            default:   op = OP_I_ALU;
        endcase
        return op;
    endfunction

    function automatic logic is_shift_imm(input opclass_e cls, input logic [2:0] funct3);
        return (cls == OPC_I_ALU) && ((funct3 == F3_SLL) || (funct3 == F3_SRX));
    endfunction

    // True when v survives truncation to 'bits' bits followed by sign extension.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i >= int'(bits) - 1) && (v[i] != v[31])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/core_iencode_fmt.sv
// Pure combinational RV32I field-bundle to instruction-word encoder.
// Define IENC_RANGE_CHECK_EN to also flag immediates that do not fit their encoding.
module core_iencode_fmt
    import core_iencode_pkg::*;
(
    input  logic [3:0]  opclass,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        err
);

    opclass_e   cls;
    logic [6:0] op;
    logic       is_shift;
    logic       class_bad;
    logic       range_bad;

    assign cls      = opclass_e'(opclass);
    assign op       = opcode_of(cls);
    assign is_shift = is_shift_imm(cls, funct3);

    always_comb begin
        word      = NOP_WORD;
        class_bad = 1'b0;
        case (cls)
            OPC_R:
                word = {funct7, rs2, rs1, funct3, rd, op};
            OPC_I_ALU: begin
                if (is_shift) begin
                    word = {funct7, imm[4:0], rs1, funct3, rd, op};
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, op};
                end
            end
            OPC_LOAD:
                word = {imm[11:0], rs1, funct3, rd, op};
            OPC_JALR:
                word = {imm[11:0], rs1, 3'b000, rd, op};
            OPC_S:
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
            OPC_B:
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
            OPC_JAL:
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            OPC_LUI, OPC_AUIPC:
                word = {imm[31:12], rd, op};
            default: begin
                word      = NOP_WORD;
                class_bad = 1'b1;
            end
        endcase
    end

`ifdef IENC_RANGE_CHECK_EN
    // Out-of-range immediates are still encoded from the truncated fields above, only flagged here.
    always_comb begin
        range_bad = 1'b0;
        case (cls)
            OPC_I_ALU: begin
                if (is_shift) begin
                    range_bad = (imm > 32'd31);
                end else begin
                    range_bad = !fits_signed(imm, 12);
                end
            end
            OPC_LOAD, OPC_JALR, OPC_S:
                range_bad = !fits_signed(imm, 12);
            OPC_B:
                range_bad = !fits_signed(imm, 13) || imm[0];
            OPC_JAL:
                range_bad = !fits_signed(imm, 21) || imm[0];
            default:
                range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    assign err = class_bad | range_bad;

endmodule

// File: rtl/core_iencode.sv
// RV32I instruction encoder with a 2-entry output FIFO, valid/ready handshakes and a handoff counter.
// Define IENC_RANGE_CHECK_EN to enable immediate range flagging in the encoder.
module core_iencode
    import core_iencode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opclass,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic        err,
    output logic [15:0] count
);

    enc_entry_t  mem [2];
    enc_entry_t  enc;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;
    logic        push;
    logic        pop;
    logic [15:0] count_q;

    core_iencode_fmt u_fmt (
        .opclass (opclass),
        .funct3  (funct3),
        .funct7  (funct7),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .imm     (imm),
        .word    (enc.word),
        .err     (enc.err)
    );

    // Ready depends only on stored occupancy (and reset), never on the consumer side.
    assign in_ready  = !rst && (occ < 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign instruction = mem[rd_ptr].word;
    assign err         = mem[rd_ptr].err;
    assign count       = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            occ     <= 2'd0;
            count_q <= 16'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= !rd_ptr;
                count_q <= count_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_iencode.sv
// Self-checking bench for core_iencode: arithmetic reference model plus directed literal vectors.
// Honours IENC_RANGE_CHECK_EN so the expected ERR matches the build.
module tb_core_iencode;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opclass;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        err;
    logic [15:0] count;

    int tests = 0;
    int fails = 0;
    bit modelOn = 0;

    typedef struct {
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [15:0] expCount = 16'd0;

    typedef struct {
        string       name;
        logic [3:0]  c;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] im;
        logic [31:0] expWord;
        logic        expErr;
    } vec_t;

`ifdef IENC_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    vec_t vecs[11];

    core_iencode dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opclass     (opclass),
        .funct3      (funct3),
        .funct7      (funct7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .err         (err),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder built from field positions with shifts and masks, range rules as signed bounds.
    function automatic void modelEncode(input logic [3:0] c, input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [31:0] im, output logic [31:0] w, output logic e);
        int   si;
        logic rangeErr;
        logic [31:0] regs;
        si       = $signed(im);
        rangeErr = 1'b0;
        e        = 1'b0;
        w        = 32'h13;
        regs     = (32'(s2) << 20) | (32'(s1) << 15);
        case (c)
            4'd0: w = (32'(f7) << 25) | regs | (32'(f3) << 12) | (32'(d) << 7) | 32'h33;
            4'd1: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    w = (32'(f7) << 25) | ((im & 32'd31) << 20);
                    rangeErr = (im > 32'd31);
                end else begin
                    w = (im & 32'hFFF) << 20;
                    rangeErr = (si < -2048) || (si > 2047);
                end
                w = w | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h13;
            end
            4'd2: begin
                w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h03;
                rangeErr = (si < -2048) || (si > 2047);
            end
            4'd3: begin
                w = (((im >> 5) & 32'd127) << 25) | regs | (32'(f3) << 12) | ((im & 32'd31) << 7) | 32'h23;
                rangeErr = (si < -2048) || (si > 2047);
            end
            4'd4: begin
                w = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'd63) << 25) | regs | (32'(f3) << 12)
                    | (((im >> 1) & 32'd15) << 8) | (((im >> 11) & 32'd1) << 7) | 32'h63;
                rangeErr = (si < -4096) || (si > 4095) || im[0];
            end
            4'd5: begin
                w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'd1023) << 21) | (((im >> 11) & 32'd1) << 20)
                    | (((im >> 12) & 32'd255) << 12) | (32'(d) << 7) | 32'h6F;
                rangeErr = (si < -1048576) || (si > 1048575) || im[0];
            end
            4'd6: begin
                w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(d) << 7) | 32'h67;
                rangeErr = (si < -2048) || (si > 2047);
            end
            4'd7: w = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'h37;
            4'd8: w = (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'h17;
            default: begin
                w = 32'h13;
                e = 1'b1;
            end
        endcase
        if (RC) begin
            e = e | rangeErr;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the queue model, then advance the model past the coming edge.
    always @(negedge clk) begin
        logic        expReady;
        logic        expValid;
        logic [31:0] w;
        logic        e;
        if (modelOn) begin
            expReady = !rst && (q.size() < 2);
            expValid = (q.size() > 0);
            checkOutput("model in_ready", 32'(in_ready), 32'(expReady));
            checkOutput("model out_valid", 32'(out_valid), 32'(expValid));
            checkOutput("model count", 32'(count), 32'(expCount));
            if (expValid) begin
                checkOutput("model instruction", instruction, q[0].word);
                checkOutput("model err", 32'(err), 32'(q[0].err));
            end
            if (rst) begin
                q.delete();
                expCount = 16'd0;
            end else begin
                if (expValid && out_ready) begin
                    void'(q.pop_front());
                    expCount = expCount + 16'd1;
                end
                if (in_valid && expReady) begin
                    modelEncode(opclass, funct3, funct7, rd, rs1, rs2, imm, w, e);
                    q.push_back('{word: w, err: e});
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic driveFields(input vec_t v);
        opclass = v.c;
        funct3  = v.f3;
        funct7  = v.f7;
        rd      = v.d;
        rs1     = v.s1;
        rs2     = v.s2;
        imm     = v.im;
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        driveFields(v);
        in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            cycle();
            n++;
        end
        checkOutput("accept within bound", 32'(n < 20), 32'd1);
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = '{"addi",      4'd1,  3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd5,          32'h0050_0093, 1'b0};
        vecs[1]  = '{"sw",        4'd3,  3'd2, 7'd0,  5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_A423, 1'b0};
        vecs[2]  = '{"beq -4",    4'd4,  3'd0, 7'd0,  5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC,  32'hFE00_0EE3, 1'b0};
        vecs[3]  = '{"jal",       4'd5,  3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'h0000_0800,  32'h0010_00EF, 1'b0};
        vecs[4]  = '{"lui",       4'd7,  3'd0, 7'd0,  5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0};
        vecs[5]  = '{"slli",      4'd1,  3'd1, 7'd0,  5'd2, 5'd3, 5'd0, 32'd3,          32'h0031_9113, 1'b0};
        vecs[6]  = '{"undef 12",  4'd12, 3'd5, 7'd9,  5'd7, 5'd4, 5'd6, 32'd77,         32'h0000_0013, 1'b1};
        vecs[7]  = '{"addi 2048", 4'd1,  3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd2048,       32'h8000_0093, RC};
        vecs[8]  = '{"jalr",      4'd6,  3'd7, 7'd0,  5'd1, 5'd2, 5'd0, 32'd4,          32'h0041_00E7, 1'b0};
        vecs[9]  = '{"auipc",     4'd8,  3'd0, 7'd0,  5'd3, 5'd0, 5'd0, 32'hABCD_E123,  32'hABCD_E197, 1'b0};
        vecs[10] = '{"add",       4'd0,  3'd0, 7'd0,  5'd3, 5'd1, 5'd2, 32'd0,          32'h0020_81B3, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        driveFields(vecs[0]);
        cycle();
        modelOn = 1;
        cycle();
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset instruction", instruction, 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("first cycle in_ready", 32'(in_ready), 32'd1);

        // Directed encodings, each word checked in the cycle after its accept.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("%s valid", vecs[i].name), 32'(out_valid), 32'd1);
            checkOutput($sformatf("%s word", vecs[i].name), instruction, vecs[i].expWord);
            checkOutput($sformatf("%s err", vecs[i].name), 32'(err), 32'(vecs[i].expErr));
        end
        cycle();

        // Backpressure: two accepts fill the FIFO, the third offer is refused and withdrawn.
        rst = 1'b1;
        out_ready = 1'b0;
        cycle();
        rst = 1'b0;
        applyStimulus(vecs[0]);
        applyStimulus(vecs[1]);
        driveFields(vecs[2]);
        in_valid = 1'b1;
        #1;
        checkOutput("full in_ready", 32'(in_ready), 32'd0);
        cycle();
        checkOutput("full in_ready held", 32'(in_ready), 32'd0);
        checkOutput("full head word", instruction, 32'h0050_0093);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        checkOutput("drain second word", instruction, 32'h0020_A423);
        cycle();
        checkOutput("drain count", 32'(count), 32'd2);
        checkOutput("drain empty", 32'(out_valid), 32'd0);

        // Reset with two entries buffered discards them.
        out_ready = 1'b0;
        applyStimulus(vecs[3]);
        applyStimulus(vecs[4]);
        checkOutput("buffered before reset", 32'(out_valid), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("reset drops entries", 32'(out_valid), 32'd0);
        checkOutput("reset drops count", 32'(count), 32'd0);

        // Stream until the counter sits at 0xFFFF, then one more handoff wraps it.
        out_ready = 1'b1;
        driveFields(vecs[5]);
        in_valid = 1'b1;
        n = 0;
        while (count != 16'hFFFF && n < 70000) begin
            cycle();
            n++;
        end
        checkOutput("count reaches FFFF", 32'(count), 32'h0000_FFFF);
        in_valid = 1'b0;
        cycle();
        checkOutput("count wraps", 32'(count), 32'd0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
